req_encoder: RTL and testbench



---
 rtl/req_encoder.sv | 125 ++++++++++++
 tb/tb_req_encoder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/req_encoder.sv
// Sequential 32-to-5 request encoder: sticky pending capture, one-index-per-grant encoding, valid/ready offer.
// Define ROUND_ROBIN_EN for rotating priority; the default build uses fixed lowest-index-first priority.
module req_encoder #(
  parameter int N_REQ = 32,
  parameter int IDX_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_in,
  input  logic [N_REQ-1:0]   mask,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [IDX_W-1:0]   out_idx,
  output logic [N_REQ-1:0]   pending,
  output logic [IDX_W:0]     pend_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    OFFER  = 2'd2
  } state_t;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_REQ-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [IDX_W:0] popcount(input logic [N_REQ-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      c = c + (IDX_W+1)'(v[i]);
    end
    return c;
  endfunction

`ifdef ROUND_ROBIN_EN
  // Rotate so rr_ptr lands at bit 0, pick lowest, then undo the rotation (mod 32 wrap).
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                               input logic [IDX_W-1:0] ptr);
    logic [2*N_REQ-1:0] dbl;
    dbl = {v, v} >> ptr;
    return lowest_idx(dbl[N_REQ-1:0]) + ptr;
  endfunction
`endif

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   pending_q, pending_d;
  logic [IDX_W:0]     pend_cnt_q, pend_cnt_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;
  logic [N_REQ-1:0]   clr, elig, elig_nxt;
  logic [IDX_W-1:0]   sel_idx;
  logic               handshake;

  assign out_valid = (state_q == OFFER);
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign pend_cnt  = pend_cnt_q;

  assign handshake = out_valid && out_ready;

  // Clear is applied before the OR so a same-cycle request on the granted bit wins.
  assign clr        = handshake ? ({{(N_REQ-1){1'b0}}, 1'b1} << out_idx_q) : '0;
  assign pending_d  = (pending_q & ~clr) | req_in;
  assign pend_cnt_d = popcount(pending_d);
  assign elig       = pending_q & ~mask;
  assign elig_nxt   = pending_d & ~mask;

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  assign rr_ptr_d = handshake ? (out_idx_q + IDX_W'(1)) : rr_ptr_q;
  assign sel_idx  = rr_pick(elig, rr_ptr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  assign sel_idx = lowest_idx(elig);
`endif

  always_comb begin
    state_d   = state_q;
    out_idx_d = out_idx_q;
    case (state_q)
      IDLE: begin
        if (|elig) state_d = SELECT;
      end
      SELECT: begin
        // Eligibility can vanish between IDLE and SELECT if mask changes; never encode zero.
        if (|elig) begin
          out_idx_d = sel_idx;
          state_d   = OFFER;
        end else begin
          state_d = IDLE;
        end
      end
      OFFER: begin
        if (handshake) state_d = (|elig_nxt) ? SELECT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      pend_cnt_q <= '0;
      out_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      pend_cnt_q <= pend_cnt_d;
      out_idx_q  <= out_idx_d;
    end
  end

endmodule

// File: tb/tb_req_encoder.sv
// Directed bench for req_encoder; expectations follow the ROUND_ROBIN_EN build setting.
module tb_req_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req_in;
  logic [31:0] mask;
  logic        out_ready;
  logic        out_valid;
  logic [4:0]  out_idx;
  logic [31:0] pending;
  logic [5:0]  pend_cnt;

  int errs   = 0;
  int checks = 0;

  req_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .mask      (mask),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pending   (pending),
    .pend_cnt  (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] rr_exp [4];
`ifdef ROUND_ROBIN_EN
    rr_exp = '{5'd0, 5'd1, 5'd0, 5'd1};
`else
    rr_exp = '{5'd0, 5'd0, 5'd0, 5'd0};
`endif
    rst_n = 1'b0; req_in = '0; mask = '0; out_ready = 1'b1;
    #12;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_idx", {27'b0, out_idx}, 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_cnt", {26'b0, pend_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: single request, latency and clear
    req_in = 32'h0000_0001;
    tick();
    req_in = '0;
    chk("t1_pend", pending, 32'h1);
    chk("t1_cnt", {26'b0, pend_cnt}, 32'd1);
    chk("t1_v_e0", {31'b0, out_valid}, 32'd0);
    tick();
    chk("t1_v_e1", {31'b0, out_valid}, 32'd0);
    tick();
    chk("t1_v_e2", {31'b0, out_valid}, 32'd1);
    chk("t1_idx", {27'b0, out_idx}, 32'd0);
    tick();
    chk("t1_pend_clr", pending, 32'h0);
    chk("t1_cnt_clr", {26'b0, pend_cnt}, 32'd0);
    chk("t1_v_done", {31'b0, out_valid}, 32'd0);

    // 2: two bits, fixed order 4 then 31 (round robin from ptr 1 gives the same)
    req_in = 32'h8000_0010;
    tick();
    req_in = '0;
    chk("t2_cnt2", {26'b0, pend_cnt}, 32'd2);
    tick(); tick();
    chk("t2_v_a", {31'b0, out_valid}, 32'd1);
    chk("t2_idx_a", {27'b0, out_idx}, 32'd4);
    tick();
    chk("t2_cnt1", {26'b0, pend_cnt}, 32'd1);
    chk("t2_v_gap", {31'b0, out_valid}, 32'd0);
    tick();
    chk("t2_v_b", {31'b0, out_valid}, 32'd1);
    chk("t2_idx_b", {27'b0, out_idx}, 32'd31);
    tick();
    chk("t2_cnt0", {26'b0, pend_cnt}, 32'd0);

    // 3: masked pending bit is held but not offered
    mask = 32'h0000_0080; req_in = 32'h0000_0080;
    tick();
    req_in = '0;
    tick(); tick(); tick();
    chk("t3_v_masked", {31'b0, out_valid}, 32'd0);
    chk("t3_pend", pending, 32'h80);
    mask = '0;
    tick(); tick();
    chk("t3_v", {31'b0, out_valid}, 32'd1);
    chk("t3_idx", {27'b0, out_idx}, 32'd7);
    tick();
    chk("t3_pend_clr", pending, 32'h0);

    // 4: offer is stable against mask changes and new requests
    out_ready = 1'b0; req_in = 32'h0000_0008;
    tick();
    req_in = '0;
    tick(); tick();
    chk("t4_idx", {27'b0, out_idx}, 32'd3);
    mask = 32'hFFFF_FFFF; req_in = 32'h0000_0001;
    tick();
    req_in = '0;
    chk("t4_v_hold", {31'b0, out_valid}, 32'd1);
    chk("t4_idx_hold", {27'b0, out_idx}, 32'd3);
    chk("t4_pend", pending, 32'h9);
    mask = '0; out_ready = 1'b1;
    tick();
    chk("t4_pend_after", pending, 32'h1);
    tick();
    chk("t4_idx0", {27'b0, out_idx}, 32'd0);
    chk("t4_v0", {31'b0, out_valid}, 32'd1);
    tick();
    chk("t4_empty", pending, 32'h0);

    // 5: set wins over clear on the granted bit
    out_ready = 1'b0; req_in = 32'h0000_0020;
    tick();
    req_in = '0;
    tick(); tick();
    chk("t5_idx", {27'b0, out_idx}, 32'd5);
    out_ready = 1'b1; req_in = 32'h0000_0020;
    tick();
    req_in = '0; out_ready = 1'b0;
    chk("t5_pend_kept", pending, 32'h20);
    tick();
    chk("t5_reoffer_v", {31'b0, out_valid}, 32'd1);
    chk("t5_reoffer_idx", {27'b0, out_idx}, 32'd5);
    out_ready = 1'b1;
    tick();
    chk("t5_clr", pending, 32'h0);
    tick();

    // 6: held requests, grant order, then reset mid-offer
    req_in = 32'h0000_0003;
    tick();
    for (int g = 0; g < 4; g++) begin
      tick(); tick();
      chk($sformatf("t6_v%0d", g), {31'b0, out_valid}, 32'd1);
      chk($sformatf("t6_idx%0d", g), {27'b0, out_idx}, {27'b0, rr_exp[g]});
    end
    rst_n = 1'b0;
    #1;
    chk("t6_rst_v", {31'b0, out_valid}, 32'd0);
    chk("t6_rst_pend", pending, 32'h0);
    chk("t6_rst_cnt", {26'b0, pend_cnt}, 32'd0);
    chk("t6_rst_idx", {27'b0, out_idx}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
